// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst read controller turning a 1-cycle-latency RAM read port into a valid/ready stream.
// A 2-entry buffer absorbs read latency and backpressure so a burst sustains one word per cycle.
module ram_stream_reader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  i_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic {IDLE, READ} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;
    logic                  r_last0, r_last1;
    logic [1:0]            r_count;
    logic                  r_inflight, r_inflight_last;
    logic                  w_pop, w_issue, w_to_head;
    logic [2:0]            w_outstanding;

    assign w_pop         = out_valid && out_ready;
    assign w_outstanding = {1'b0, r_count} + {2'b0, r_inflight};
    // count + inflight - pop <= 1, rearranged to stay unsigned
    assign w_issue       = r_state == READ && r_remaining != '0 && w_outstanding <= 3'd1 + {2'b0, w_pop};
    assign w_to_head     = r_count == {1'b0, w_pop};

    assign cmd_ready = r_state == IDLE;
    assign busy      = r_state == READ;
    assign ram_re    = w_issue;
    assign ram_raddr = r_addr;
    assign out_valid = r_count != 2'd0;
    assign out_data  = r_data0;
    assign out_last  = r_last0 && out_valid;

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_data0         <= '0;
            r_data1         <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
            r_count         <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue)
                r_inflight_last <= r_remaining == LEN_WIDTH'(1);
            if (r_state == IDLE) begin
                if (cmd_valid && cmd_len != '0) begin
                    r_state     <= READ;
                    r_addr      <= cmd_addr;
                    r_remaining <= cmd_len;
                end
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr == ADDR_WIDTH'(DEPTH - 1) ? '0 : r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_pop && r_last0)
                    r_state <= IDLE;
            end
            if (w_pop) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
            end
            // returning word lands in the first free slot after any pop this cycle
            if (r_inflight && w_to_head) begin
                r_data0 <= ram_rdata;
                r_last0 <= r_inflight_last;
            end
            if (r_inflight && !w_to_head) begin
                r_data1 <= ram_rdata;
                r_last1 <= r_inflight_last;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: RAM model plus queue scoreboard; expected words come from address arithmetic
// on the RAM contents mem[i] = 3*i, and a negedge monitor compares every read issue and stream word.
module tb_ram_stream_reader;
    localparam int DW = 32, DEPTH = 512, AW = 9, LW = 10;

    logic          clk = 1'b0, i_rstn = 1'b1, cmd_valid = 1'b0;
    logic          fixed_ready = 1'b1, rnd_ready = 1'b0, rnd_bit = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_ready, ram_re, out_valid, out_last, busy, out_ready;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata, out_data;

    int            n_cmp = 0, n_bad = 0, n_iss = 0, n_pop = 0;
    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic [AW-1:0] q_addr[$];
    logic          p_hold = 1'b0, p_nonlast = 1'b0, p_last = 1'b0;
    logic [DW-1:0] p_data = '0;

    ram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .i_rstn(i_rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_re(ram_re), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    assign out_ready = rnd_ready ? rnd_bit : fixed_ready;

    always @(posedge clk) if (ram_re) ram_rdata <= DW'(3 * int'(ram_raddr));
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!i_rstn) begin
            q_data.delete();
            q_last.delete();
            q_addr.delete();
            n_iss = 0;
            n_pop = 0;
            p_hold = 1'b0;
            p_nonlast = 1'b0;
        end else begin
            check("busy_vs_pending", busy, q_data.size() != 0);
            check("cmd_ready_vs_busy", cmd_ready, !busy);
            if (p_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, p_data);
                check("hold_last", out_last, p_last);
            end
            if (p_nonlast) check("stream_gap", out_valid, 1);
            check("outstanding_le2", n_iss - n_pop <= 2, 1);
            if (ram_re) begin
                if (q_addr.size() == 0) check("spurious_read", ram_re, 0);
                else begin
                    check("raddr", ram_raddr, q_addr.pop_front());
                    n_iss++;
                end
            end
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) check("spurious_word", out_valid, 0);
                else begin
                    check("data", out_data, q_data.pop_front());
                    check("last", out_last, q_last.pop_front());
                    n_pop++;
                end
            end
            p_hold = out_valid && !out_ready;
            p_data = out_data;
            p_last = out_last;
            p_nonlast = out_valid && out_ready && !out_last;
            if (cmd_valid && cmd_ready)
                for (int i = 0; i < int'(cmd_len); i++) begin
                    q_addr.push_back(AW'((int'(cmd_addr) + i) % DEPTH));
                    q_data.push_back(DW'(3 * ((int'(cmd_addr) + i) % DEPTH)));
                    q_last.push_back(i == int'(cmd_len) - 1);
                end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int addr, input int len);
        int t = 0;
        cmd_addr = AW'(addr);
        cmd_len = LW'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || out_valid || q_data.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", busy, 0);
        tick();
    endtask

    initial begin
        int t;
        i_rstn = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_re", ram_re, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        i_rstn = 1'b1;
        send(10, 4);
        @(negedge clk);
        check("lat_re_cycle1", ram_re, 1);
        check("lat_valid_cycle1", out_valid, 0);
        @(negedge clk);
        check("lat_valid_cycle2", out_valid, 0);
        @(negedge clk);
        check("lat_valid_cycle3", out_valid, 1);
        wait_idle();
        send(510, 4);
        wait_idle();
        send(0, 8);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_first_valid", out_valid, 1);
        tick();
        fixed_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_re_low", ram_re, 0);
        check("bp_valid_held", out_valid, 1);
        tick();
        fixed_ready = 1'b1;
        wait_idle();
        send(5, 0);
        repeat (4) begin
            @(negedge clk);
            check("len0_re", ram_re, 0);
            check("len0_valid", out_valid, 0);
            check("len0_busy", busy, 0);
            check("len0_cmd_ready", cmd_ready, 1);
        end
        tick();
        send(20, 6);
        t = 0;
        while (n_pop < 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        tick();
        i_rstn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_re", ram_re, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_last", out_last, 0);
        tick();
        i_rstn = 1'b1;
        send(100, 2);
        wait_idle();
        rnd_ready = 1'b1;
        send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
        send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
        for (int k = 0; k < 12; k++)
            send(int'($urandom_range(0, DEPTH - 1)), (k % 5 == 2) ? 0 : int'($urandom_range(1, 40)));
        send(300, DEPTH);
        wait_idle();
        rnd_ready = 1'b0;
        check("scoreboard_drained", q_data.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
